// File: rtl/sim_halt_monitor.sv
// End-of-test controller: all-channel halt, error with drain delay, global timeout and
// optional per-channel no-commit watchdog (enabled by defining SIM_HALT_MONITOR_STALL_EN).
module sim_halt_monitor #(
  parameter int unsigned NUM_CH         = 1,
  parameter int unsigned ERR_W          = 16,
  parameter int unsigned CYC_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter int unsigned STALL_CYCLES   = 10000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       commit,
  input  logic [NUM_CH-1:0]       halt,
  input  logic [NUM_CH*ERR_W-1:0] errcode,
  output logic                    done,
  output logic [2:0]              cause,
  output logic [$clog2(NUM_CH):0] cause_ch,
  output logic [ERR_W-1:0]        err_q,
  output logic [CYC_W-1:0]        cycles
);

  localparam int unsigned CH_W  = $clog2(NUM_CH) + 1;
  localparam int unsigned DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [2:0] CAUSE_HALT    = 3'd1;
  localparam logic [2:0] CAUSE_ERROR   = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_STALL   = 3'd4;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CH-1:0] halted_q, halted_q_d, halted;
  logic              all_halted;
  logic [CH_W-1:0]   halt_ch;
  logic              err_hit;
  logic [CH_W-1:0]   err_ch;
  logic [ERR_W-1:0]  err_code;
  logic              stall_hit;
  logic [CH_W-1:0]   stall_ch;
  logic              timeout_hit;
  logic [DRN_W-1:0]  drain_cnt, drain_cnt_d;

  logic              done_d;
  logic [2:0]        cause_d;
  logic [CH_W-1:0]   cause_ch_d;
  logic [ERR_W-1:0]  err_q_d;
  logic [CYC_W-1:0]  cycles_d;

  // A channel is "halted" once latched, on its strobe this edge, or when disabled
  assign halted      = halted_q | halt | ~ch_en;
  assign all_halted  = &halted;
  assign timeout_hit = (cycles == CYC_W'(TIMEOUT_CYCLES - 1));

  always_comb begin : event_detect
    err_hit  = 1'b0;
    err_ch   = '0;
    err_code = '0;
    halt_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!err_hit && ch_en[i] && (errcode[i*ERR_W +: ERR_W] != '0)) begin
        err_hit  = 1'b1;
        err_ch   = CH_W'(i);
        err_code = errcode[i*ERR_W +: ERR_W];
      end
      if (halt[i]) begin
        halt_ch = CH_W'(i);
      end
    end
  end

`ifdef SIM_HALT_MONITOR_STALL_EN
  localparam int unsigned STL_W = $clog2(STALL_CYCLES);

  logic [STL_W-1:0] stall_cnt [NUM_CH];

  always_comb begin : stall_detect
    stall_hit = 1'b0;
    stall_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!stall_hit && !halted[i] && !commit[i] &&
          (stall_cnt[i] == STL_W'(STALL_CYCLES - 1))) begin
        stall_hit = 1'b1;
        stall_ch  = CH_W'(i);
      end
    end
  end

  // Counts consecutive RUN edges without a commit on an active channel
  always_ff @(posedge clk) begin : stall_count
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst) begin
        stall_cnt[i] <= '0;
      end else if (state == S_RUN) begin
        if (commit[i] || halted[i]) begin
          stall_cnt[i] <= '0;
        end else if (stall_cnt[i] != '1) begin
          stall_cnt[i] <= stall_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic [NUM_CH-1:0] unused_commit;
  logic [31:0]       unused_stall_cycles;

  assign unused_commit       = commit;
  assign unused_stall_cycles = STALL_CYCLES;
  assign stall_hit           = 1'b0;
  assign stall_ch            = '0;
`endif

  always_ff @(posedge clk) begin : state_reg
    if (!rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    unique case (state)
      S_RUN: begin
        if (err_hit) begin
          state_nxt = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end else if (all_halted || stall_hit || timeout_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRN_W'(1)) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_DONE;
    endcase
  end

  // Next values of the registered outputs; priority ERROR > HALT > STALL > TIMEOUT
  always_comb begin : output_next
    done_d      = done;
    cause_d     = cause;
    cause_ch_d  = cause_ch;
    err_q_d     = err_q;
    cycles_d    = cycles;
    drain_cnt_d = drain_cnt;
    halted_q_d  = halted_q;
    unique case (state)
      S_RUN: begin
        cycles_d   = cycles + 1'b1;
        halted_q_d = halted_q | (halt & ch_en);
        if (err_hit) begin
          cause_d     = CAUSE_ERROR;
          cause_ch_d  = err_ch;
          err_q_d     = err_code;
          drain_cnt_d = DRN_W'(DRAIN_CYCLES);
        end else if (all_halted) begin
          cause_d    = CAUSE_HALT;
          cause_ch_d = halt_ch;
        end else if (stall_hit) begin
          cause_d    = CAUSE_STALL;
          cause_ch_d = stall_ch;
        end else if (timeout_hit) begin
          cause_d    = CAUSE_TIMEOUT;
          cause_ch_d = '0;
        end
      end
      S_DRAIN: begin
        cycles_d    = cycles + 1'b1;
        drain_cnt_d = drain_cnt - 1'b1;
      end
      default: ;
    endcase
    done_d = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin : out_regs
    if (!rst) begin
      done      <= 1'b0;
      cause     <= '0;
      cause_ch  <= '0;
      err_q     <= '0;
      cycles    <= '0;
      drain_cnt <= '0;
      halted_q  <= '0;
    end else begin
      done      <= done_d;
      cause     <= cause_d;
      cause_ch  <= cause_ch_d;
      err_q     <= err_q_d;
      cycles    <= cycles_d;
      drain_cnt <= drain_cnt_d;
      halted_q  <= halted_q_d;
    end
  end

endmodule

// File: doc/sim_halt_monitor.md
Name: sim_halt_monitor

Overview:
- Parametrised, multi-channel simulation end-of-test controller for the testbench top.
- Replaces per-testbench halting logic: all-channel halt, errcode with drain delay, global timeout and per-channel no-commit watchdog.
- Fully registered, deterministic cause/channel reporting.
- One instance sits beside the RVFI interfaces (one channel per hart); its `done` drives `$finish` in the bench.

Parameters:
- NUM_CH, 1, number of monitored channels (harts), 1..16.
- ERR_W, 16, errcode width per channel.
- CYC_W, 32, cycle counter width.
- TIMEOUT_CYCLES, 100000000, global timeout in cycles; must be < 2^CYC_W.
- DRAIN_CYCLES, 5, cycles between error capture and done; 0 allowed.
- STALL_CYCLES, 10000, max consecutive cycles without a commit on an enabled, unhalted channel; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- ch_en  in  NUM_CH  channel enable; a disabled channel counts as halted and is ignored for error and stall
- commit  in  NUM_CH  per-channel instruction commit strobe
- halt  in  NUM_CH  per-channel halt strobe
- errcode  in  NUM_CH*ERR_W  per-channel error code, channel i at [i*ERR_W +: ERR_W]; nonzero means error
- done  out  1  level; test finished
- cause  out  3  0 NONE, 1 HALT, 2 ERROR, 3 TIMEOUT, 4 STALL
- cause_ch  out  $clog2(NUM_CH)+1  channel responsible; 0 for TIMEOUT
- err_q  out  ERR_W  captured errcode; 0 unless cause is ERROR
- cycles  out  CYC_W  cycles elapsed since reset release, frozen at done

Behaviour:
- Reset (rst==0 at posedge, any state, including mid-drain or DONE):
  - state=RUN; all outputs 0; halted_q=0; stall counters=0; drain_cnt=0.
- States:
  - RUN: normal monitoring.
  - DRAIN: error captured, counting down.
  - DONE: terminal until reset.
- All events are evaluated on the inputs at a posedge while in RUN. Outputs update at that edge, so `done` is visible one cycle after the sampled event.
- cycles: increments every edge in RUN and DRAIN; holds in DONE.
- halted_q[i]: set on halt[i] & ch_en[i]; sticky. Channel i counts as halted when halted_q[i] | halt[i] | ~ch_en[i].
- Events, all evaluated in RUN:
  - ERROR: any ch_en[i] & errcode[i]!=0.
    - Capture the lowest such i into cause_ch and its code into err_q; cause=ERROR.
    - If DRAIN_CYCLES==0, go to DONE; else go to DRAIN with drain_cnt=DRAIN_CYCLES.
  - HALT: all channels halted. Go to DONE, cause=HALT, cause_ch = highest-index channel whose halt strobe is set this edge.
  - STALL: enabled, unhalted channel i with no commit while stall_cnt[i]==STALL_CYCLES-1. Go to DONE, cause=STALL, cause_ch = lowest such i.
  - TIMEOUT: cycles==TIMEOUT_CYCLES-1. Go to DONE, cause=TIMEOUT, cause_ch=0; cycles becomes TIMEOUT_CYCLES.
- Priority on the same edge: ERROR > HALT > STALL > TIMEOUT.
- stall_cnt[i]: cleared on commit[i], when the channel is halted, or when ch_en[i]==0; otherwise increments (saturating).
- DRAIN:
  - Decrements drain_cnt each edge; at the edge where drain_cnt==1, go to DONE and assert done.
  - With DRAIN_CYCLES=N, done is registered N edges after the error edge.
  - Halt, stall, timeout and further errors are ignored; err_q and cause_ch hold.
- DONE: done=1; all outputs frozen; inputs ignored.
- NUM_CH=1: cause_ch is 1 bit wide and always 0.

Optional Feature:
- Macro: SIM_HALT_MONITOR_STALL_EN.
- Defined: per-channel stall counters and the STALL cause are present as described.
- Undefined:
  - No stall counters are built; STALL_CYCLES is unused.
  - cause never equals 4; commit is ignored.
  - Only HALT, ERROR and TIMEOUT can finish the test.

Test Plan:
- NUM_CH=2, both enabled, commits every cycle. halt[1] at cycle 10, halt[0] at cycle 20 -> done at cycle 21, cause=1, cause_ch=0, cycles=21.
- NUM_CH=2, errcode[1]=16'h0003 at cycle 50, DRAIN_CYCLES=5, halt on both at cycle 52 -> halt ignored; done high after the 5th edge following capture; cause=2, cause_ch=1, err_q=3.
- Same edge: errcode[0]=7 and all channels halt -> cause=2, cause_ch=0, err_q=7.
- TIMEOUT_CYCLES=100, commits continuous, no halt or error -> done after edge 100, cause=3, cycles=100.
- STALL_EN defined, STALL_CYCLES=8, ch_en=2'b11, commit[0] continuous, commit[1] stops at cycle 30 -> done at cycle 38, cause=4, cause_ch=1. Repeat with ch_en[1]=0 -> no stall; timeout instead.
- Drive rst low for one edge while in DRAIN (drain_cnt=3) -> all outputs 0, state RUN; counting restarts at 0.
